// File: rtl/instream_mc_if.sv
// Per-channel stream port of instream_mc: one valid/ready pair and one W-bit word per channel.
// A word moves when valid && ready at a rising clk; the source holds valid and out steady while valid && !ready.
interface instream_mc_if #(
  parameter int CH = 2,
  parameter int W  = 11
);
  logic [CH-1:0]   valid;
  logic [CH-1:0]   ready;
  logic [CH*W-1:0] out;

  modport master (output valid, output out, input ready);
  modport slave  (input valid, input out, output ready);
endinterface

// File: rtl/instream_mc.sv
// instream_mc: multi-channel source streaming preloaded signed words over valid/ready.
// Wrap-around looping per channel is built only when INSTREAM_LOOP_EN is defined.
module instream_mc #(
  parameter int W     = 11,
  parameter int DEPTH = 64,
  parameter int CH    = 2,
  parameter int LW    = $clog2(DEPTH + 1),
  parameter int CW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ld_en,
  input  logic [CW-1:0]    i_ld_ch,
  input  logic [LW-1:0]    i_ld_addr,
  input  logic [W-1:0]     i_ld_data,
  input  logic [CH*LW-1:0] i_length,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_loop,
  instream_mc_if.master    m_if,
  output logic [CH-1:0]    o_done,
  output logic             o_busy,
  output logic             o_ld_err,
  output logic [2*CH-1:0]  o_state
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  logic [W-1:0]  r_mem   [CH][DEPTH];
  state_t        r_state [CH];
  state_t        w_nxt   [CH];
  logic [LW-1:0] r_pos   [CH];
  logic [LW-1:0] r_len   [CH];
  logic [LW-1:0] w_len_in[CH];
  logic [W-1:0]  r_out   [CH];
  logic [CH-1:0] w_xfer, w_last, w_loop, w_nxt_stream, w_accept;
  logic          r_busy, r_ld_err, w_ld_stream;
  logic [CH-1:0]   w_valid, w_done;
  logic [CH*W-1:0] w_out;
  logic [2*CH-1:0] w_state;

`ifdef INSTREAM_LOOP_EN
  logic [CH-1:0] r_loop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_loop <= '0;
    end else begin
      for (int c = 0; c < CH; c++)
        if (w_accept[c]) r_loop[c] <= i_loop;
    end
  end

  assign w_loop = r_loop;
`else
  logic w_unused_loop;
  assign w_unused_loop = i_loop;
  assign w_loop        = '0;
`endif

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      w_nxt[c]    = r_state[c];
      w_len_in[c] = (i_length[c*LW +: LW] > LW'(DEPTH)) ? LW'(DEPTH) : i_length[c*LW +: LW];
      w_xfer[c]   = (r_state[c] == S_STREAM) && m_if.ready[c];
      w_last[c]   = (r_pos[c] == r_len[c] - LW'(1));
      w_accept[c] = i_start && !i_abort && (r_state[c] != S_STREAM);
      if (i_abort) begin
        w_nxt[c] = S_IDLE;
      end else begin
        case (r_state[c])
          S_IDLE, S_DONE: if (i_start) w_nxt[c] = (w_len_in[c] == '0) ? S_DONE : S_STREAM;
          S_STREAM:       if (w_xfer[c] && w_last[c] && !w_loop[c]) w_nxt[c] = S_DONE;
          default:        w_nxt[c] = S_IDLE;
        endcase
      end
      w_nxt_stream[c] = (w_nxt[c] == S_STREAM);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) r_state[c] <= S_IDLE;
    end else begin
      for (int c = 0; c < CH; c++) r_state[c] <= w_nxt[c];
    end
  end

  // Next word is fetched on the transfer edge so a new word is presented every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        r_pos[c] <= '0;
        r_len[c] <= '0;
        r_out[c] <= '0;
      end
      r_busy   <= 1'b0;
      r_ld_err <= 1'b0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (w_accept[c]) begin
          r_len[c] <= w_len_in[c];
          r_pos[c] <= '0;
          r_out[c] <= r_mem[c][0];
        end else if (!i_abort && w_xfer[c] && !w_last[c]) begin
          r_pos[c] <= r_pos[c] + LW'(1);
          r_out[c] <= r_mem[c][AW'(r_pos[c] + LW'(1))];
        end else if (!i_abort && w_xfer[c] && w_loop[c]) begin
          r_pos[c] <= '0;
          r_out[c] <= r_mem[c][0];
        end
      end
      r_busy <= |w_nxt_stream;
      if (w_ld_stream) r_ld_err <= 1'b1;
    end
  end

  assign w_ld_stream = i_ld_en && (r_state[i_ld_ch] == S_STREAM);

  // Buffer contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (i_ld_en && !w_ld_stream && (i_ld_addr < LW'(DEPTH)))
      r_mem[i_ld_ch][i_ld_addr[AW-1:0]] <= i_ld_data;
  end

  always_comb begin
    w_valid = '0;
    w_done  = '0;
    w_out   = '0;
    w_state = '0;
    for (int c = 0; c < CH; c++) begin
      w_valid[c]         = (r_state[c] == S_STREAM);
      w_done[c]          = (r_state[c] == S_DONE);
      w_out[c*W +: W]    = r_out[c];
      w_state[2*c +: 2]  = r_state[c];
    end
  end

  assign m_if.valid = w_valid;
  assign m_if.out   = w_out;
  assign o_done     = w_done;
  assign o_state    = w_state;
  assign o_busy     = r_busy;
  assign o_ld_err   = r_ld_err;
endmodule
